// File: rtl/cp_pkg.sv
// Shared definitions for the synchronous copy-stage arbiter:
// packet field positions, packet widths, FSM states and the
// copy-destination helper.
package cp_pkg;

  // Field positions inside the 40-bit hold register
  localparam int DEST_HI     = 28;
  localparam int DEST_LO     = 22;
  localparam int LR_ORIG_BIT = 21;
  localparam int LR_COPY_BIT = 20;
  localparam int CPY_BIT     = 18;

  // Packet widths on the upstream and downstream sides
  localparam int PKT_IN_W  = 40;
  localparam int PKT_OUT_W = 38;

  localparam int DEST_W = DEST_HI - DEST_LO + 1;

  // Emission sequencing: nothing held, original presented, copy presented
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ORIG  = 2'd1,
    COPY  = 2'd2
  } cpState_t;

  // Identity of the requester that won the most recent transfer
  typedef enum logic {
    GRANT_A = 1'b0,
    GRANT_B = 1'b1
  } cpPort_t;

  // The copy goes to the next destination, wrapping 127 back to 0
  function automatic logic [DEST_W-1:0] nextDest(input logic [DEST_W-1:0] dest);
    return dest + DEST_W'(1);
  endfunction

endpackage

// File: rtl/copy_rr_arb2.sv
// Two-requester round-robin arbiter. The grant is purely
// combinational from the requests and the remembered last winner;
// the last winner only moves when the caller commits a transfer, so
// a requester that withdraws without being served keeps its turn.
module copy_rr_arb2
  import cp_pkg::*;
(
  input  logic       CP,
  input  logic       MR_n,
  input  logic [1:0] i_req,
  input  logic       i_commit,
  output logic [1:0] o_grant
);

  cpPort_t    r_lastGrant;
  logic [1:0] w_grant;

  // Grant selection: a lone requester always wins, a tie goes to the port that did not win last
  always_comb begin
    w_grant = 2'b00;
    case (i_req)
      2'b01:   w_grant = 2'b01;
      2'b10:   w_grant = 2'b10;
      2'b11:   w_grant = (r_lastGrant == GRANT_B) ? 2'b01 : 2'b10;
      default: w_grant = 2'b00;
    endcase
  end

  // Last-winner register; resets to B so that A wins the first tie
  always_ff @(posedge CP) begin
    if (!MR_n) begin
      r_lastGrant <= GRANT_B;
    end else if (i_commit) begin
      r_lastGrant <= w_grant[1] ? GRANT_B : GRANT_A;
    end
  end

  assign o_grant = w_grant;

endmodule

// File: rtl/copy_stage_arbiter.sv
// Clocked copy stage shared between two upstream ports. A granted
// packet is latched into the hold register, then emitted downstream
// once, or twice (original then copy) when its CPY flag is set.
// Upstream accepts are only possible while nothing is held, which
// keeps Ack_in out of any combinational path to Ack_out_a/b.
module copy_stage_arbiter
  import cp_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                 CP,
  input  logic                 MR_n,
  input  logic                 Send_in_a,
  input  logic [PKT_IN_W-1:0]  PACKET_IN_a,
  output logic                 Ack_out_a,
  input  logic                 Send_in_b,
  input  logic [PKT_IN_W-1:0]  PACKET_IN_b,
  output logic                 Ack_out_b,
  output logic                 Send_out,
  output logic [PKT_OUT_W-1:0] PACKET_OUT,
  input  logic                 Ack_in,
  output logic                 Copy_phase,
  output logic [CNT_W-1:0]     Cpy_count
);

  cpState_t            r_state;
  cpState_t            w_stateNext;
  logic [PKT_IN_W-1:0] r_dl;
  logic [CNT_W-1:0]    r_cpyCount;

  logic [1:0]          w_grant;
  logic                w_ackA;
  logic                w_ackB;
  logic                w_inXfer;
  logic                w_outXfer;
  logic                w_sendOut;
  logic                w_copyPhase;
  logic [DEST_W-1:0]   w_destOut;
  logic                w_lrOut;

  copy_rr_arb2 u_arb (
    .CP       (CP),
    .MR_n     (MR_n),
    .i_req    ({Send_in_b, Send_in_a}),
    .i_commit (w_inXfer),
    .o_grant  (w_grant)
  );

  // Next-state and handshake outputs; accepts are suppressed while reset is held so no packet looks taken
  always_comb begin
    w_stateNext = r_state;
    w_sendOut   = 1'b0;
    w_copyPhase = 1'b0;
    w_ackA      = 1'b0;
    w_ackB      = 1'b0;
    case (r_state)
      EMPTY: begin
        w_ackA = MR_n && w_grant[0] && Send_in_a;
        w_ackB = MR_n && w_grant[1] && Send_in_b;
        if (w_ackA || w_ackB) begin
          w_stateNext = ORIG;
        end
      end
      ORIG: begin
        w_sendOut = 1'b1;
        if (Ack_in) begin
          w_stateNext = r_dl[CPY_BIT] ? COPY : EMPTY;
        end
      end
      COPY: begin
        w_sendOut   = 1'b1;
        w_copyPhase = 1'b1;
        if (Ack_in) begin
          w_stateNext = EMPTY;
        end
      end
      default: begin
        w_stateNext = EMPTY;
      end
    endcase
  end

  assign w_inXfer  = w_ackA || w_ackB;
  assign w_outXfer = w_sendOut && Ack_in;

  // State register
  always_ff @(posedge CP) begin
    if (!MR_n) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Hold register: loads the granted packet on an accept and otherwise keeps it stable
  always_ff @(posedge CP) begin
    if (!MR_n) begin
      r_dl <= '0;
    end else if (w_ackA) begin
      r_dl <= PACKET_IN_a;
    end else if (w_ackB) begin
      r_dl <= PACKET_IN_b;
    end
  end

  // Copy-event counter: counts delivered copies and sticks at all-ones
  always_ff @(posedge CP) begin
    if (!MR_n) begin
      r_cpyCount <= '0;
    end else if (w_outXfer && (r_state == COPY) && (r_cpyCount != '1)) begin
      r_cpyCount <= r_cpyCount + CNT_W'(1);
    end
  end

  // Downstream formatting: the copy gets the next destination and its own LR bit
  always_comb begin
    w_destOut = r_dl[DEST_HI:DEST_LO];
    w_lrOut   = r_dl[LR_ORIG_BIT];
    if (r_state == COPY) begin
      w_destOut = nextDest(r_dl[DEST_HI:DEST_LO]);
      w_lrOut   = r_dl[LR_COPY_BIT];
    end
  end

  assign PACKET_OUT = {r_dl[PKT_IN_W-1:DEST_HI+1], w_destOut, w_lrOut,
                       r_dl[LR_COPY_BIT-1], r_dl[CPY_BIT-1:0]};
  assign Ack_out_a  = w_ackA;
  assign Ack_out_b  = w_ackB;
  assign Send_out   = w_sendOut;
  assign Copy_phase = w_copyPhase;
  assign Cpy_count  = r_cpyCount;

endmodule

// File: tb/tb_copy_stage_arbiter.sv
// Self-checking bench for copy_stage_arbiter. The reference model
// keeps the packets still owed downstream in a queue, together with
// a flag marking copies, the last winning port and the copy count.
module tb_copy_stage_arbiter;

  localparam int CNT_W = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             CP;
  logic             MR_n;
  logic             Send_in_a;
  logic [39:0]      PACKET_IN_a;
  logic             Ack_out_a;
  logic             Send_in_b;
  logic [39:0]      PACKET_IN_b;
  logic             Ack_out_b;
  logic             Send_out;
  logic [37:0]      PACKET_OUT;
  logic             Ack_in;
  logic             Copy_phase;
  logic [CNT_W-1:0] Cpy_count;

  logic [37:0] expQ[$];
  bit          copyQ[$];
  bit          lastGrantB;
  int          expCount;
  bit          dlZero;

  int testsRun;
  int testsFailed;

  copy_stage_arbiter #(.CNT_W(CNT_W)) dut (
    .CP          (CP),
    .MR_n        (MR_n),
    .Send_in_a   (Send_in_a),
    .PACKET_IN_a (PACKET_IN_a),
    .Ack_out_a   (Ack_out_a),
    .Send_in_b   (Send_in_b),
    .PACKET_IN_b (PACKET_IN_b),
    .Ack_out_b   (Ack_out_b),
    .Send_out    (Send_out),
    .PACKET_OUT  (PACKET_OUT),
    .Ack_in      (Ack_in),
    .Copy_phase  (Copy_phase),
    .Cpy_count   (Cpy_count)
  );

  // Free-running clock
  initial CP = 1'b0;
  always #5 CP = ~CP;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Downstream view of a held packet, straight from the field map
  function automatic logic [37:0] fmtPacket(input logic [39:0] p, input bit isCopy);
    int         dest;
    bit         lr;
    logic [6:0] dest7;
    dest = int'(p[28:22]);
    lr   = p[21];
    if (isCopy) begin
      dest = (dest + 1) % 128;
      lr   = p[20];
    end
    dest7 = 7'(dest);
    return {p[39:29], dest7, lr, p[19], p[17:0]};
  endfunction

  task automatic applyStimulus(input bit mr, input bit sa, input logic [39:0] pa,
                               input bit sb, input logic [39:0] pb, input bit ackIn);
    MR_n        = mr;
    Send_in_a   = sa;
    PACKET_IN_a = pa;
    Send_in_b   = sb;
    PACKET_IN_b = pb;
    Ack_in      = ackIn;
  endtask

  // One clock cycle: drive, check mid-cycle against the model, then advance the model at the edge
  task automatic runCycle(input bit mr, input bit sa, input logic [39:0] pa,
                          input bit sb, input logic [39:0] pb, input bit ackIn, input bit doCheck);
    bit empty, grantA, grantB, expAckA, expAckB;
    applyStimulus(mr, sa, pa, sb, pb, ackIn);
    #3;
    empty   = (expQ.size() == 0);
    grantA  = sa && (!sb || lastGrantB);
    grantB  = sb && (!sa || !lastGrantB);
    expAckA = mr && empty && grantA;
    expAckB = mr && empty && grantB;
    if (doCheck) begin
      checkOutput("Send_out", Send_out, !empty);
      checkOutput("Ack_out_a", Ack_out_a, expAckA);
      checkOutput("Ack_out_b", Ack_out_b, expAckB);
      checkOutput("Cpy_count", Cpy_count, expCount);
      if (!empty) begin
        checkOutput("PACKET_OUT", PACKET_OUT, expQ[0]);
        checkOutput("Copy_phase", Copy_phase, copyQ[0]);
      end else begin
        checkOutput("Copy_phase_idle", Copy_phase, 0);
        if (dlZero) checkOutput("PACKET_OUT_reset", PACKET_OUT, 0);
      end
    end
    @(posedge CP);
    if (!mr) begin
      expQ.delete();
      copyQ.delete();
      lastGrantB = 1'b1;
      expCount   = 0;
      dlZero     = 1'b1;
    end else if (!empty && ackIn) begin
      if (copyQ[0] && expCount < CNT_MAX) expCount++;
      void'(expQ.pop_front());
      void'(copyQ.pop_front());
    end else if (expAckA || expAckB) begin
      logic [39:0] p;
      p = expAckA ? pa : pb;
      expQ.push_back(fmtPacket(p, 1'b0));
      copyQ.push_back(1'b0);
      if (p[18]) begin
        expQ.push_back(fmtPacket(p, 1'b1));
        copyQ.push_back(1'b1);
      end
      lastGrantB = expAckB;
      dlZero     = 1'b0;
    end
    #1;
  endtask

  function automatic logic [39:0] randPacket();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[39:0];
  endfunction

  function automatic logic [39:0] mkPacket(input logic [6:0] dest, input bit lrO, input bit lrC, input bit cpy);
    logic [39:0] p;
    p        = randPacket();
    p[28:22] = dest;
    p[21]    = lrO;
    p[20]    = lrC;
    p[18]    = cpy;
    return p;
  endfunction

  initial begin
    logic [39:0] p;
    testsRun    = 0;
    testsFailed = 0;
    lastGrantB  = 1'b1;
    expCount    = 0;
    dlZero      = 1'b1;
    applyStimulus(1'b0, 1'b1, '0, 1'b1, '0, 1'b0);
    @(posedge CP);
    #1;

    // Reset held with both ports requesting
    runCycle(0, 1, randPacket(), 1, randPacket(), 1, 0);
    runCycle(0, 1, randPacket(), 1, randPacket(), 1, 1);
    runCycle(0, 1, randPacket(), 1, randPacket(), 0, 1);

    // Plain packet on A
    p = mkPacket(7'h05, 1, 0, 0);
    runCycle(1, 1, p, 0, '0, 1, 1);
    checkOutput("plainDest", PACKET_OUT[26:20], 7'h05);
    checkOutput("plainLr", PACKET_OUT[19], 1);
    runCycle(1, 0, '0, 0, '0, 1, 1);
    checkOutput("plainDone", Send_out, 0);
    checkOutput("plainCount", Cpy_count, 0);

    // Copy packet on B with destination wrap
    p = mkPacket(7'h7F, 0, 1, 1);
    runCycle(1, 0, '0, 1, p, 1, 1);
    checkOutput("origDest", PACKET_OUT[26:20], 7'h7F);
    checkOutput("origLr", PACKET_OUT[19], 0);
    checkOutput("origPhase", Copy_phase, 0);
    runCycle(1, 0, '0, 0, '0, 1, 1);
    checkOutput("copyDest", PACKET_OUT[26:20], 7'h00);
    checkOutput("copyLr", PACKET_OUT[19], 1);
    checkOutput("copyPhase", Copy_phase, 1);
    runCycle(1, 0, '0, 0, '0, 1, 1);
    checkOutput("copyCount", Cpy_count, 1);
    checkOutput("copyDone", Send_out, 0);

    // Backpressure in ORIG then COPY while both ports keep requesting
    runCycle(1, 1, mkPacket(7'h33, 1, 0, 1), 0, '0, 0, 1);
    for (int i = 0; i < 5; i++) runCycle(1, 1, randPacket(), 1, randPacket(), 0, 1);
    runCycle(1, 1, randPacket(), 1, randPacket(), 1, 1);
    for (int i = 0; i < 5; i++) runCycle(1, 1, randPacket(), 1, randPacket(), 0, 1);
    runCycle(1, 0, '0, 0, '0, 1, 1);
    checkOutput("bpCount", Cpy_count, 2);

    // Contention from reset: grants must alternate starting with A
    runCycle(0, 0, '0, 0, '0, 0, 1);
    for (int i = 0; i < 16; i++) runCycle(1, 1, randPacket(), 1, randPacket(), 1, 1);

    // Reset while the copy is stalled, then a fresh A packet
    runCycle(1, 1, mkPacket(7'h10, 0, 1, 1), 0, '0, 1, 1);
    runCycle(1, 0, '0, 0, '0, 1, 1);
    checkOutput("preResetPhase", Copy_phase, 1);
    runCycle(0, 0, '0, 0, '0, 0, 1);
    checkOutput("postResetSend", Send_out, 0);
    checkOutput("postResetCount", Cpy_count, 0);
    runCycle(1, 1, mkPacket(7'h21, 1, 0, 0), 0, '0, 1, 1);
    runCycle(1, 0, '0, 0, '0, 1, 1);

    // Copy counter saturation
    for (int i = 0; i < CNT_MAX + 4; i++) begin
      runCycle(1, 1, mkPacket(7'(i), 0, 1, 1), 0, '0, 1, 1);
      runCycle(1, 0, '0, 0, '0, 1, 1);
      runCycle(1, 0, '0, 0, '0, 1, 1);
    end
    checkOutput("cpySaturate", Cpy_count, CNT_MAX);

    // Randomized traffic with occasional resets and backpressure
    for (int i = 0; i < 3000; i++) begin
      runCycle(($urandom_range(0, 149) != 0),
               $urandom_range(0, 1) == 1, randPacket(),
               $urandom_range(0, 1) == 1, randPacket(),
               $urandom_range(0, 3) != 0, 1);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
